// File: rtl/sms4_key_expand.sv
// SMS4 key schedule: one round key per clock from a 128-bit master key.
// The four key words slide through a window; each round derives the next word T.

module sms4_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };
  assign y = SBOX[a];
endmodule

module sms4_key_expand #(
  parameter int BWIDTH = 32,
  parameter int ROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*BWIDTH-1:0]   mk,
  output logic                  busy,
  output logic                  rk_valid,
  output logic [4:0]            rk_idx,
  output logic [BWIDTH-1:0]     rk,
  output logic                  done
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0]  LAST = 5'(ROUNDS - 1);
  localparam logic [31:0] FK0  = 32'hA3B1BAC6;
  localparam logic [31:0] FK1  = 32'h56AA3350;
  localparam logic [31:0] FK2  = 32'h677D9197;
  localparam logic [31:0] FK3  = 32'hB27022DC;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [31:0] rk_q, rk_d;
  logic [4:0]  rk_idx_q, rk_idx_d;
  logic        rk_valid_q, rk_valid_d, done_q, done_d, busy_q, busy_d;
  logic [31:0] x_s, b_s, l_s, t_s;

  // CK byte j is (4*cnt+j)*7 mod 256; {cnt,j} is exactly 4*cnt+j.
  function automatic logic [31:0] ck_word(input logic [4:0] c);
    logic [31:0] w;
    logic [7:0]  n;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      n = {1'b0, c, 2'(j)};
      w[31-8*j -: 8] = n * 8'd7;
    end
    return w;
  endfunction

  assign x_s = k1_q ^ k2_q ^ k3_q ^ ck_word(cnt_q);

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    sms4_sbox u_sbox (.a(x_s[31-8*j -: 8]), .y(b_s[31-8*j -: 8]));
  end

  assign l_s = b_s ^ {b_s[18:0], b_s[31:19]} ^ {b_s[8:0], b_s[31:9]};
  assign t_s = k0_q ^ l_s;

  // Next-state and datapath selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k0_d       = k0_q;
    k1_d       = k1_q;
    k2_d       = k2_q;
    k3_d       = k3_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k0_d    = mk[127:96] ^ FK0;
          k1_d    = mk[95:64]  ^ FK1;
          k2_d    = mk[63:32]  ^ FK2;
          k3_d    = mk[31:0]   ^ FK3;
          cnt_d   = 5'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rk_d       = t_s;
        rk_idx_d   = cnt_q;
        rk_valid_d = 1'b1;
        k0_d       = k1_q;
        k1_d       = k2_q;
        k2_d       = k3_q;
        k3_d       = t_s;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      k0_q       <= 32'h0;
      k1_q       <= 32'h0;
      k2_q       <= 32'h0;
      k3_q       <= 32'h0;
      rk_q       <= 32'h0;
      rk_idx_q   <= 5'd0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k0_q       <= k0_d;
      k1_q       <= k1_d;
      k2_q       <= k2_d;
      k3_q       <= k3_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk       = rk_q;
  assign done     = done_q;
endmodule

// File: tb/tb_sms4_key_expand.sv
// Bench for sms4_key_expand: textbook K[i+4] recurrence model, directed and random runs.
module tb_sms4_key_expand;
  logic         clk = 1'b0;
  logic         rst, start, start4;
  logic [127:0] mk, mk4;
  logic         busy, rk_valid, done, busy4, rk_valid4, done4;
  logic [4:0]   rk_idx, rk_idx4;
  logic [31:0]  rk, rk4;

  localparam logic [127:0] KEY1 = 128'h0123456789ABCDEFFEDCBA9876543210;

  sms4_key_expand dut (.clk(clk), .rst(rst), .start(start), .mk(mk), .busy(busy),
    .rk_valid(rk_valid), .rk_idx(rk_idx), .rk(rk), .done(done));
  sms4_key_expand #(.ROUNDS(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .mk(mk4), .busy(busy4),
    .rk_valid(rk_valid4), .rk_idx(rk_idx4), .rk(rk4), .done(done4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] got_rk [$];
  int          got_idx [$];
  bit          got_done [$];
  int          got_cyc [$];
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          stray_cnt = 0;

  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      got_rk.push_back(rk);
      got_idx.push_back(int'(rk_idx));
      got_done.push_back(done === 1'b1);
      got_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (done === 1'b1 && rk_valid !== 1'b1) stray_cnt <= stray_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ck(input int i);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++) w = (w << 8) | 32'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  logic [31:0] exp_rk [32];

  task automatic model(input logic [127:0] m);
    logic [31:0] k [36];
    logic [31:0] x, b;
    k[0] = m[127:96] ^ 32'hA3B1BAC6;
    k[1] = m[95:64]  ^ 32'h56AA3350;
    k[2] = m[63:32]  ^ 32'h677D9197;
    k[3] = m[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i);
      b = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      exp_rk[i] = k[i+4];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] m, output int e0);
    start = 1'b1;
    mk = m;
    tick();
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: done count %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; mk = '0; mk4 = '0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b rk_valid=%b done=%b, required 0", busy, rk_valid, done);
    end
    checks++;
    if (rk !== 32'h0 || rk_idx !== 5'd0) begin
      errors++; $display("FAIL reset_data: rk=%h idx=%0d, required 0/0", rk, rk_idx);
    end
    checks++;
    if (busy4 !== 1'b0 || rk_valid4 !== 1'b0 || done4 !== 1'b0 || rk4 !== 32'h0) begin
      errors++; $display("FAIL reset_r4: busy=%b v=%b done=%b rk=%h, required 0", busy4, rk_valid4, done4, rk4);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || got_rk.size() != 0) begin
      errors++; $display("FAIL idle_hold: busy=%b rk_valid=%b keys=%0d, required 0", busy, rk_valid, got_rk.size());
    end
  endtask

  task automatic test_single_run(input logic [127:0] m, input string name, input bit consts);
    int base, d0, b0, e0;
    model(m);
    base = got_rk.size(); d0 = done_cnt; b0 = busy_cnt;
    pulse_start(m, e0);
    wait_done(d0 + 1, 40, name);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_in_done_cycle: got %b, required 0", name, busy);
    end
    checks++;
    if (got_rk.size() != base + 32) begin
      errors++; $display("FAIL %s strobes: got %0d, required 32", name, got_rk.size() - base);
    end
    for (int i = 0; i < 32; i++) begin
      if (base + i < got_rk.size()) begin
        checks++;
        if (got_rk[base+i] !== exp_rk[i] || got_idx[base+i] != i || got_done[base+i] != (i == 31) ||
            got_cyc[base+i] != e0 + 1 + i) begin
          errors++;
          $display("FAIL %s key%0d: got rk=%h idx=%0d done=%0b cyc=%0d, required rk=%h idx=%0d done=%0b cyc=%0d",
                   name, i, got_rk[base+i], got_idx[base+i], got_done[base+i], got_cyc[base+i],
                   exp_rk[i], i, (i == 31), e0 + 1 + i);
        end
      end
    end
    if (consts && got_rk.size() >= base + 32) begin
      checks++;
      if (got_rk[base] !== 32'hF12186F9 || got_rk[base+1] !== 32'h41662B61 || got_rk[base+31] !== 32'h9124A012) begin
        errors++;
        $display("FAIL %s vectors: got %h %h %h, required F12186F9 41662B61 9124A012",
                 name, got_rk[base], got_rk[base+1], got_rk[base+31]);
      end
    end
    checks++;
    if (busy_cnt - b0 != 32 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s busy/done: busy cycles %0d done %0d, required 32/1", name, busy_cnt - b0, done_cnt - d0);
    end
  endtask

  task automatic test_start_held();
    logic [31:0]  e1 [32];
    logic [127:0] m2;
    int base, d0, n;
    model(KEY1);
    e1 = exp_rk;
    m2 = {$urandom, $urandom, $urandom, $urandom};
    model(m2);
    base = got_rk.size(); d0 = done_cnt;
    start = 1'b1; mk = KEY1;
    tick();
    n = 0;
    while (done_cnt < d0 + 1 && n < 40) begin
      mk = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    checks++;
    if (done_cnt < d0 + 1) begin
      errors++; $display("FAIL t3 timeout: done count %0d, required %0d", done_cnt, d0 + 1);
    end
    mk = m2;
    tick();
    start = 1'b0;
    wait_done(d0 + 2, 40, "t3_second");
    checks++;
    if (got_rk.size() != base + 64) begin
      errors++; $display("FAIL t3 strobes: got %0d, required 64", got_rk.size() - base);
    end
    for (int i = 0; i < 64; i++) begin
      if (base + i < got_rk.size()) begin
        checks++;
        if (got_rk[base+i] !== ((i < 32) ? e1[i] : exp_rk[i-32]) || got_idx[base+i] != i % 32) begin
          errors++;
          $display("FAIL t3 key%0d: got rk=%h idx=%0d, required rk=%h idx=%0d", i, got_rk[base+i],
                   got_idx[base+i], (i < 32) ? e1[i] : exp_rk[i-32], i % 32);
        end
      end
    end
    if (got_rk.size() >= base + 33) begin
      checks++;
      if (got_cyc[base+32] != got_cyc[base+31] + 2) begin
        errors++; $display("FAIL t3 restart_gap: got %0d cycles, required 2", got_cyc[base+32] - got_cyc[base+31]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int base, d0, b0, e0, n;
    base = got_rk.size(); d0 = done_cnt;
    pulse_start(KEY1, e0);
    n = 0;
    while (got_rk.size() < base + 10 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (got_rk.size() != base + 10 || got_idx[got_rk.size()-1] != 9) begin
      errors++; $display("FAIL t4 reach_rk9: got %0d keys, required 10", got_rk.size() - base);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk !== 32'h0 || rk_idx !== 5'd0) begin
      errors++;
      $display("FAIL t4 after_rst: v=%b busy=%b done=%b rk=%h idx=%0d, required all 0", rk_valid, busy, done, rk, rk_idx);
    end
    b0 = busy_cnt;
    repeat (40) tick();
    checks++;
    if (got_rk.size() != base + 10 || done_cnt != d0 || busy_cnt != b0) begin
      errors++;
      $display("FAIL t4 quiet: keys %0d done %0d busy %0d, required 10/0/0",
               got_rk.size() - base, done_cnt - d0, busy_cnt - b0);
    end
    test_single_run(KEY1, "t4_rerun", 1'b1);
  endtask

  task automatic test_rounds4();
    int k = 0, b = 0, dn = 0;
    model(KEY1);
    start4 = 1'b1; mk4 = KEY1;
    tick();
    start4 = 1'b0;
    repeat (10) begin
      if (busy4 === 1'b1) b++;
      if (done4 === 1'b1) dn++;
      if (rk_valid4 === 1'b1) begin
        checks++;
        if (k > 3 || rk4 !== exp_rk[k % 32] || rk_idx4 !== 5'(k) || done4 !== (k == 3)) begin
          errors++;
          $display("FAIL t5 key%0d: got rk=%h idx=%0d done=%b, required rk=%h idx=%0d done=%0b",
                   k, rk4, rk_idx4, done4, exp_rk[k % 32], k, (k == 3));
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 4 || b != 4 || dn != 1) begin
      errors++; $display("FAIL t5 counts: keys %0d busy %0d done %0d, required 4/4/1", k, b, dn);
    end
  endtask

  task automatic test_random();
    int base0, base, d0, e0, bad;
    logic [127:0] m;
    base0 = got_rk.size();
    for (int r = 0; r < 32; r++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      model(m);
      repeat ($urandom_range(0, 5)) tick();
      base = got_rk.size(); d0 = done_cnt;
      pulse_start(m, e0);
      wait_done(d0 + 1, 40, "t6_run");
      for (int i = 0; i < 32; i++) begin
        if (base + i < got_rk.size()) begin
          checks++;
          bad = (got_rk[base+i] !== exp_rk[i] || got_idx[base+i] != i || got_done[base+i] != (i == 31) ||
                 got_cyc[base+i] != e0 + 1 + i) ? 1 : 0;
          if (bad != 0) begin
            errors++;
            $display("FAIL t6 run%0d key%0d: got rk=%h idx=%0d done=%0b, required rk=%h idx=%0d done=%0b",
                     r, i, got_rk[base+i], got_idx[base+i], got_done[base+i], exp_rk[i], i, (i == 31));
          end
        end
      end
    end
    tick();
    checks++;
    if (got_rk.size() - base0 != 32 * 32) begin
      errors++; $display("FAIL t6 total_keys: got %0d, required %0d", got_rk.size() - base0, 32 * 32);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_run(KEY1, "t1", 1'b1);
    repeat (3) tick();
    test_single_run(128'h0, "t2", 1'b0);
    repeat (2) tick();
    test_start_held();
    repeat (2) tick();
    test_rst_mid();
    repeat (2) tick();
    test_rounds4();
    test_random();
    checks++;
    if (stray_cnt != 0) begin
      errors++; $display("FAIL stray_done: got %0d done pulses without rk_valid, required 0", stray_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
